memory_controller_queued: RTL and testbench
===========================================

// Module: memory_controller_queued
// PURPOSE
//  Data-memory front end for the OoO core's load/store unit. Buffers up to QUEUE_DEPTH
//  requests in a FIFO and issues them one at a time on the dmem port. Returns load results
//  (sign/zero-extended) and store completions to the ROB.
//  On branch_mispredict it kills queued and in-flight loads; committed stores still drain.
// PARAMETERS
//  QUEUE_DEPTH     4             request FIFO entries; power of 2, >=2
//  ROB_ID_BITS     ROB_ID_SIZE   width of rob_id carried with each request
// PORTS
//  clk               in   1      clock
//  rst               in   1      synchronous, active-high reset
//  branch_mispredict in   1      flush pulse from ROB; kills loads, keeps stores
//  req_valid         in   1      request offered this cycle
//  req_ready         out  1      FIFO can accept (= !full, from registered count)
//  req               in   ls_mem_bus_t   rob_id, funct3, dmem_addr[31:0], dmem_rmask[3:0], dmem_wmask[3:0], dmem_wdata[31:0]
//  dmem_addr         out  32     word-aligned address {addr[31:2],2'b00}
//  dmem_rmask        out  4      read byte mask; non-zero only in ISSUE
//  dmem_wmask        out  4      write byte mask; non-zero only in ISSUE
//  dmem_wdata        out  32     store data
//  dmem_rdata        in   32     load data, valid with dmem_resp
//  dmem_resp         in   1      memory response, one-cycle pulse
//  mem_rob_data_o    out  mem_rob_data_bus_t   ready, rob_id, rd_data, dmem_rdata, store
//  mem_state         out  2      current FSM state
//  queue_count       out  $clog2(QUEUE_DEPTH)+1   occupied FIFO entries
// BEHAVIOUR
//  Reset: FIFO empty; head/tail pointers 0; FSM = IDLE; req_ready=1; mem_rob_data_o.ready=0;
//   dmem masks=0; queue_count=0. A reset mid-transaction discards the outstanding response.
//  Enqueue: on req_valid && req_ready, write req at tail with kill=0; tail wraps mod QUEUE_DEPTH.
//   When full, req_ready=0, even if a dequeue happens in the same cycle (no full-bypass).
//  Store vs load: an entry is a store iff wmask!=0, else a load iff rmask!=0. Both masks zero is illegal.
//  FSM states:
//   IDLE:  FIFO empty -> stay in IDLE.
//          Head has kill=1 -> pop it, stay in IDLE (one cycle per killed entry, no dmem activity).
//          Otherwise -> pop head into the in-flight register and go to ISSUE.
//   ISSUE: drive dmem_* from the in-flight register for exactly 1 cycle -> WAIT.
//   WAIT:  masks=0. On dmem_resp -> IDLE. If not killed, emit the result this same cycle.
//  Result (combinational, during WAIT with dmem_resp):
//   - ready=1 and rob_id copied from the request.
//   - Store: store=1.
//   - Load: store=0, dmem_rdata passed through, rd_data per funct3:
//     lb/lbu: byte at addr[1:0], sign/zero-extended.
//     lh/lhu: halfword at addr[1], sign/zero-extended.
//     lw: full word.
//  Latency: a request accepted at T into an empty queue with FSM in IDLE pops at T+1,
//   issues at T+2, and returns in the cycle dmem_resp arrives. Next issue is at resp+2 at the earliest.
//  Flush (branch_mispredict=1):
//   - Every queued load gets kill=1; stores keep kill=0.
//   - An accepted load in the same cycle is enqueued with kill=1.
//   - An in-flight load gets an inflight_kill bit: the FSM still completes ISSUE/WAIT
//     (the memory access cannot be aborted) but suppresses ready.
//   - An in-flight store completes normally.
//   - FIFO pointers and count are untouched by a flush.
//  Enqueue and dequeue in the same cycle: count is unchanged and both take effect.
//  Unused output fields default to 'x; ready and dmem masks are never x.
// STRUCTURE
//  rv32i_types (shared package):
//   - ls_mem_bus_t, mem_rob_data_bus_t
//   - funct3 load encodings (lb,lh,lw,lbu,lhu)
//   - mem_idle/mem_issue/mem_wait state enum (2 bits)
//   - new mem_q_entry_t = {ls_mem_bus_t req; logic kill;}
//  Sub-module: mem_req_fifo (parametrised circular FIFO of mem_q_entry_t)
//   - Ports: push, pop, head, full, empty, count, plus a kill_loads input that sets kill on load entries.
//   - The FSM, in-flight register and load alignment stay in memory_controller_queued.
// TESTING
//  1 Word load: push lw addr=0x100, rob_id=3; dmem_resp 2 cycles after issue with rdata=0xDEADBEEF
//    -> ready=1, rob_id=3, rd_data=0xDEADBEEF, store=0.
//  2 Byte/half extension, rdata=0x80FF7F01:
//    lb addr=0x203 -> 0xFFFFFF80; lbu addr=0x202 -> 0x000000FF; lh addr=0x202 -> 0xFFFF80FF;
//    lhu addr=0x200 -> 0x00007F01.
//  3 Backpressure: QUEUE_DEPTH=4, dmem_resp held low; push 5 reqs back-to-back
//    -> req_ready=0 after 4 accepted, queue_count=4; releasing resp drains all in FIFO order with correct rob_ids.
//  4 Flush mix: queue holds [sw rob1, lw rob2, sw rob3] plus lw rob0 in WAIT; pulse branch_mispredict
//    -> rob0 response suppressed; rob1 and rob3 store completions emitted; rob2 popped with no dmem activity.
//  5 Flush in the same cycle as a load push plus a dequeue: entry killed, count correct, pointers wrap past DEPTH-1 with no loss.
//  6 Reset during WAIT: rst=1 for 1 cycle, then a stale dmem_resp -> no ready, state=IDLE, queue_count=0, req_ready=1.

Source files
------------

// File: rtl/memory_controller_queued_pkg.sv
// rtl/memory_controller_queued_pkg.sv - shared types for the queued data-memory front end
// Purpose: request/response bus structs, funct3 load encodings, FSM state enum,
//          FIFO entry type and the load-alignment / store-detection helpers.
// Ports:   none (package).
package memory_controller_queued_pkg;

  localparam int ROB_ID_SIZE = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [ROB_ID_SIZE-1:0] rob_id;
    logic [2:0]             funct3;
    logic [31:0]            dmem_addr;
    logic [3:0]             dmem_rmask;
    logic [3:0]             dmem_wmask;
    logic [31:0]            dmem_wdata;
  } ls_mem_bus_t;

  typedef struct packed {
    logic                   ready;
    logic [ROB_ID_SIZE-1:0] rob_id;
    logic [31:0]            rd_data;
    logic [31:0]            dmem_rdata;
    logic                   store;
  } mem_rob_data_bus_t;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_ISSUE = 2'd1,
    MEM_WAIT  = 2'd2
  } mem_state_t;

  typedef struct packed {
    ls_mem_bus_t req;
    logic        kill;
  } mem_q_entry_t;

  // A non-zero write mask marks a store; anything else is treated as a load.
  function automatic logic is_store(input ls_mem_bus_t r);
    return r.dmem_wmask != 4'b0000;
  endfunction

  // Select and extend the addressed byte/halfword of a word-aligned read.
  function automatic logic [31:0] load_align(input logic [2:0]  funct3,
                                             input logic [1:0]  addr_lo,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   res = {{24{b[7]}}, b};
      F3_LBU:  res = {24'h0, b};
      F3_LH:   res = {{16{h[15]}}, h};
      F3_LHU:  res = {16'h0, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/memory_controller_queued_fifo.sv
// rtl/memory_controller_queued_fifo.sv - circular request FIFO with load-kill support
// Purpose: holds mem_q_entry_t requests in arrival order; kill_loads_i marks every
//          stored load as killed without moving pointers or count.
// Ports:   clk_i, rst_i (sync, active-high); push_i/push_data_i enqueue at tail;
//          pop_i dequeues head; kill_loads_i flush marker; head_o, full_o,
//          empty_o, count_o report FIFO status from registered state.
module mem_req_fifo
  import memory_controller_queued_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  mem_q_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         kill_loads_i,
  output mem_q_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  mem_q_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Stale slots may get marked too; they are rewritten on push, so harmless.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_loads_i && !is_store(mem_q[i].req)) mem_q[i].kill <= 1'b1;
      end
      // The incoming entry already carries its own kill bit, so it wins here.
      if (do_push) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (do_pop) head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_controller_queued.sv
// rtl/memory_controller_queued.sv - queued data-memory front end for the load/store unit
// Purpose: buffers LSU requests, issues them one at a time on the dmem port and returns
//          aligned load data / store completions to the ROB; a mispredict kills loads.
// Ports:   clk, rst (sync, active-high), branch_mispredict flush pulse;
//          req_valid/req_ready/req request input; dmem_addr/rmask/wmask/wdata,
//          dmem_rdata/dmem_resp memory port; mem_rob_data_o result to ROB;
//          mem_state FSM state; queue_count FIFO occupancy.
module memory_controller_queued
  import memory_controller_queued_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int ROB_ID_BITS = ROB_ID_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         branch_mispredict,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  ls_mem_bus_t                  req,
  output logic [31:0]                  dmem_addr,
  output logic [3:0]                   dmem_rmask,
  output logic [3:0]                   dmem_wmask,
  output logic [31:0]                  dmem_wdata,
  input  logic [31:0]                  dmem_rdata,
  input  logic                         dmem_resp,
  output mem_rob_data_bus_t            mem_rob_data_o,
  output logic [1:0]                   mem_state,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  mem_state_t   state_q;
  ls_mem_bus_t  inflight_q;
  logic         inflight_kill_q;

  mem_q_entry_t push_entry, head;
  logic         fifo_full, fifo_empty, push, pop;
  logic         inflight_is_load, result_fire;
  logic [ROB_ID_BITS-1:0] rob_id_w;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == MEM_IDLE) && !fifo_empty;

  always_comb begin
    push_entry      = '0;
    push_entry.req  = req;
    push_entry.kill = branch_mispredict && !is_store(req);
  end

  mem_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .kill_loads_i (branch_mispredict),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (queue_count)
  );

  assign inflight_is_load = !is_store(inflight_q);

  // Killed heads are popped by 'pop' while the FSM stays idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= MEM_IDLE;
      inflight_q      <= '0;
      inflight_kill_q <= 1'b0;
    end else begin
      unique case (state_q)
        MEM_IDLE: begin
          if (!fifo_empty && !head.kill) begin
            inflight_q      <= head.req;
            // The FIFO's own kill marking lands on the entry we are popping, so catch it here.
            inflight_kill_q <= branch_mispredict && !is_store(head.req);
            state_q         <= MEM_ISSUE;
          end
        end
        MEM_ISSUE: begin
          if (branch_mispredict && inflight_is_load) inflight_kill_q <= 1'b1;
          state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (branch_mispredict && inflight_is_load) inflight_kill_q <= 1'b1;
          if (dmem_resp) state_q <= MEM_IDLE;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  assign mem_state  = state_q;
  assign dmem_addr  = {inflight_q.dmem_addr[31:2], 2'b00};
  assign dmem_wdata = inflight_q.dmem_wdata;
  assign dmem_rmask = (state_q == MEM_ISSUE) ? inflight_q.dmem_rmask : 4'b0000;
  assign dmem_wmask = (state_q == MEM_ISSUE) ? inflight_q.dmem_wmask : 4'b0000;

  // A flush coinciding with the response also suppresses an in-flight load.
  assign result_fire = (state_q == MEM_WAIT) && dmem_resp && !inflight_kill_q &&
                       !(branch_mispredict && inflight_is_load);
  assign rob_id_w    = inflight_q.rob_id;

  always_comb begin
    mem_rob_data_o       = 'x;
    mem_rob_data_o.ready = result_fire;
    if (result_fire) begin
      mem_rob_data_o.rob_id = rob_id_w;
      mem_rob_data_o.store  = !inflight_is_load;
      if (inflight_is_load) begin
        mem_rob_data_o.rd_data    = load_align(inflight_q.funct3, inflight_q.dmem_addr[1:0],
                                               dmem_rdata);
        mem_rob_data_o.dmem_rdata = dmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_memory_controller_queued.sv
// tb/tb_memory_controller_queued.sv - scoreboard bench for memory_controller_queued
module tb_memory_controller_queued;
  import memory_controller_queued_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, branch_mispredict, req_valid, req_ready;
  ls_mem_bus_t       req;
  logic [31:0]       dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]        dmem_rmask, dmem_wmask;
  logic              dmem_resp;
  mem_rob_data_bus_t mem_rob_data_o;
  logic [1:0]        mem_state;
  logic [2:0]        queue_count;

  memory_controller_queued #(.QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .branch_mispredict(branch_mispredict),
    .req_valid(req_valid), .req_ready(req_ready), .req(req),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_rob_data_o(mem_rob_data_o), .mem_state(mem_state), .queue_count(queue_count)
  );

  typedef struct {
    logic [3:0]  rob_id;
    logic        store;
    logic [31:0] rd_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          resp_delay = 2;
  bit          hold = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  int          issues = 0;
  int          issues_mark;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: answer each issue after resp_delay cycles unless held.
  initial begin
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && (dmem_rmask != 4'b0 || dmem_wmask != 4'b0)) begin
        issues++;
        check32("addr_align", {30'b0, dmem_addr[1:0]}, 32'h0);
        repeat (resp_delay) @(negedge clk);
        while (hold) @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = mem_rdata;
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
      end
    end
  end

  // Monitor: sample one time unit before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (mem_rob_data_o.ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual rob_id=%0d expected no result",
                   mem_rob_data_o.rob_id);
        end else begin
          e = sb.pop_front();
          check32("rob_id", {28'b0, mem_rob_data_o.rob_id}, {28'b0, e.rob_id});
          check32("store", {31'b0, mem_rob_data_o.store}, {31'b0, e.store});
          if (!e.store) begin
            check32("rd_data", mem_rob_data_o.rd_data, e.rd_data);
            check32("dmem_rdata", mem_rob_data_o.dmem_rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic push(input logic [3:0] rob, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                      input bit flush);
    int n = 0;
    @(negedge clk);
    req_valid         = 1'b1;
    req.rob_id        = rob;
    req.funct3        = f3;
    req.dmem_addr     = addr;
    req.dmem_rmask    = rm;
    req.dmem_wmask    = wm;
    req.dmem_wdata    = wd;
    branch_mispredict = flush;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual req_ready=0 expected 1 rob=%0d", rob);
    end
    @(posedge clk);
  endtask

  task automatic exp_load(input logic [3:0] rob, input logic [31:0] rd);
    exp_t e;
    e.rob_id = rob; e.store = 1'b0; e.rd_data = rd; e.rdata = mem_rdata;
    sb.push_back(e);
  endtask

  task automatic exp_store(input logic [3:0] rob);
    exp_t e;
    e.rob_id = rob; e.store = 1'b1; e.rd_data = 32'h0; e.rdata = 32'h0;
    sb.push_back(e);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    req_valid         = 1'b0;
    branch_mispredict = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (n < 300 && !(sb.size() == 0 && mem_state == 2'd0 && queue_count == 3'd0 && !dmem_resp)) begin
      @(negedge clk);
      n++;
    end
    check32({name, "_drain_timeout"}, {31'b0, (n >= 300)}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; branch_mispredict = 1'b0; req_valid = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    check32("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check32("rst_count", {29'b0, queue_count}, 32'h0);
    check32("rst_state", {30'b0, mem_state}, 32'h0);
    check32("rst_ready", {31'b0, mem_rob_data_o.ready}, 32'h0);
    check32("rst_masks", {24'b0, dmem_rmask, dmem_wmask}, 32'h0);
    rst = 1'b0;

    // 1: word load
    mem_rdata = 32'hDEADBEEF; resp_delay = 2;
    exp_load(4'd3, 32'hDEADBEEF);
    push(4'd3, F3_LW, 32'h100, 4'hF, 4'h0, 32'h0, 1'b0);
    idle_bus();
    wait_drain("t1");

    // 2: byte/half extension
    mem_rdata = 32'h80FF7F01;
    exp_load(4'd4, 32'hFFFFFF80); push(4'd4, F3_LB,  32'h203, 4'h8, 4'h0, 32'h0, 1'b0);
    exp_load(4'd5, 32'h000000FF); push(4'd5, F3_LBU, 32'h202, 4'h4, 4'h0, 32'h0, 1'b0);
    exp_load(4'd6, 32'hFFFF80FF); push(4'd6, F3_LH,  32'h202, 4'hC, 4'h0, 32'h0, 1'b0);
    exp_load(4'd7, 32'h00007F01); push(4'd7, F3_LHU, 32'h200, 4'h3, 4'h0, 32'h0, 1'b0);
    idle_bus();
    wait_drain("t2");

    // 3: backpressure; one request moves in-flight, four fill the FIFO
    mem_rdata = 32'h12345678; hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_load(4'(8 + i), 32'h12345678);
      push(4'(8 + i), F3_LW, 32'h300 + 32'(4 * i), 4'hF, 4'h0, 32'h0, 1'b0);
    end
    idle_bus();
    check32("bp_count", {29'b0, queue_count}, 32'h4);
    check32("bp_req_ready", {31'b0, req_ready}, 32'h0);
    hold = 1'b0;
    wait_drain("t3");

    // 4: flush mix with lw rob0 parked in WAIT
    hold = 1'b1;
    push(4'd0, F3_LW, 32'h400, 4'hF, 4'h0, 32'h0, 1'b0);
    exp_store(4'd1); push(4'd1, F3_LW, 32'h404, 4'h0, 4'hF, 32'hA5A5A5A5, 1'b0);
    push(4'd2, F3_LW, 32'h408, 4'hF, 4'h0, 32'h0, 1'b0);
    exp_store(4'd3); push(4'd3, F3_LW, 32'h40C, 4'h0, 4'h3, 32'h5A5A5A5A, 1'b0);
    idle_bus();
    check32("mix_count", {29'b0, queue_count}, 32'h3);
    check32("mix_state_wait", {30'b0, mem_state}, 32'h2);
    issues_mark = issues;
    branch_mispredict = 1'b1;
    @(negedge clk);
    branch_mispredict = 1'b0;
    check32("mix_count_after_flush", {29'b0, queue_count}, 32'h3);
    hold = 1'b0;
    wait_drain("t4");
    check32("mix_issues", 32'(issues - issues_mark), 32'h2);

    // 5: flush on the same cycle as a load push and a dequeue
    resp_delay = 1;
    issues_mark = issues;
    exp_store(4'd6); push(4'd6, F3_LW, 32'h500, 4'h0, 4'hF, 32'h11111111, 1'b0);
    push(4'd7, F3_LW, 32'h504, 4'hF, 4'h0, 32'h0, 1'b1);
    idle_bus();
    check32("samecyc_count", {29'b0, queue_count}, 32'h1);
    check32("samecyc_state", {30'b0, mem_state}, 32'h1);
    exp_load(4'd9, 32'h12345678); push(4'd9, F3_LW, 32'h508, 4'hF, 4'h0, 32'h0, 1'b0);
    idle_bus();
    wait_drain("t5");
    check32("samecyc_issues", 32'(issues - issues_mark), 32'h2);

    // 6: reset during WAIT, then a stale response
    resp_delay = 2;
    push(4'd10, F3_LW, 32'h600, 4'hF, 4'h0, 32'h0, 1'b0);
    idle_bus();
    begin
      int n = 0;
      while (mem_state != 2'd2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check32("rst_wait_reached", {30'b0, mem_state}, 32'h2);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check32("midrst_state", {30'b0, mem_state}, 32'h0);
    check32("midrst_count", {29'b0, queue_count}, 32'h0);
    check32("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    check32("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
